// File: rtl/cla32.sv
// cla32: 32-bit two-level carry-lookahead adder with a registered 33-bit sum.
// Optional CLA32_IN_REG_EN adds an input register stage (2-cycle latency).

module cla_la4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       ci,
  output logic [3:0] c,
  output logic       pg,
  output logic       gg
);

  // Every carry is a flat sum of products of p/g and ci; none ripples.
  always_comb begin
    c[0] = ci;
    c[1] = g[0]
         | (p[0] & ci);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & ci);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    pg   = &p;
    gg   = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] sum,
  output logic       pg,
  output logic       gg
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  cla_la4 u_la (
    .p  (p),
    .g  (g),
    .ci (ci),
    .c  (c),
    .pg (pg),
    .gg (gg)
  );

  assign sum = p ^ c;

endmodule

module cla_lcu2 (
  input  logic [1:0] pg,
  input  logic [1:0] gg,
  input  logic       ci,
  output logic       c_mid,
  output logic       c_out
);

  // Top unit: carries into the upper half and out of the whole word.
  always_comb begin
    c_mid = gg[0]
          | (pg[0] & ci);
    c_out = gg[1]
          | (pg[1] & gg[0])
          | (pg[1] & pg[0] & ci);
  end

endmodule

module cla32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [32:0] s,
  output logic        out_valid
);

  logic [31:0] core_a;
  logic [31:0] core_b;
  logic        core_v;

`ifdef CLA32_IN_REG_EN
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        v_q;

  // Input stage: operands captured so the core sits between two registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
    end else begin
      a_q <= a;
      b_q <= b;
      v_q <= in_valid;
    end
  end

  assign core_a = a_q;
  assign core_b = b_q;
  assign core_v = v_q;
`else
  assign core_a = a;
  assign core_b = b;
  assign core_v = in_valid;
`endif

  logic [7:0]  pg_b;
  logic [7:0]  gg_b;
  logic [7:0]  cb;
  logic [31:0] sum;
  logic        pg_lo;
  logic        gg_lo;
  logic        pg_hi;
  logic        gg_hi;
  logic        c16;
  logic        c32;

  for (genvar i = 0; i < 8; i++) begin : g_blk
    cla4 u_blk (
      .a   (core_a[4*i +: 4]),
      .b   (core_b[4*i +: 4]),
      .ci  (cb[i]),
      .sum (sum[4*i +: 4]),
      .pg  (pg_b[i]),
      .gg  (gg_b[i])
    );
  end

  cla_la4 u_lcu_lo (
    .p  (pg_b[3:0]),
    .g  (gg_b[3:0]),
    .ci (1'b0),
    .c  (cb[3:0]),
    .pg (pg_lo),
    .gg (gg_lo)
  );

  cla_la4 u_lcu_hi (
    .p  (pg_b[7:4]),
    .g  (gg_b[7:4]),
    .ci (c16),
    .c  (cb[7:4]),
    .pg (pg_hi),
    .gg (gg_hi)
  );

  cla_lcu2 u_lcu_top (
    .pg    ({pg_hi, pg_lo}),
    .gg    ({gg_hi, gg_lo}),
    .ci    (1'b0),
    .c_mid (c16),
    .c_out (c32)
  );

  // Output stage: sum updates every cycle, out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      out_valid <= 1'b0;
    end else begin
      s         <= {c32, sum};
      out_valid <= core_v;
    end
  end

endmodule

// File: tb/tb_cla32.sv
// tb_cla32: directed and random checks of cla32 against an arithmetic
// model delayed by the configured latency.

module tb_cla32;

`ifdef CLA32_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [32:0] s;
  logic        out_valid;

  typedef struct packed {
    logic        v;
    logic [32:0] sum;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;

  cla32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .s         (s),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [32:0] got,
                     input logic [32:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input string tag);
    ent_t e;
    @(posedge clk);
    if (rst) begin
      q.delete();
      for (int i = 0; i < LAT; i++) q.push_back('0);
    end else begin
      e.v   = in_valid;
      e.sum = 33'(a) + 33'(b);
      q.push_back(e);
      void'(q.pop_front());
    end
    #1;
    chk({tag, ".s"}, s, q[0].sum);
    chk({tag, ".v"}, {32'b0, out_valid}, {32'b0, q[0].v});
  endtask

  task automatic drive(input logic [31:0] x,
                       input logic [31:0] y,
                       input logic v);
    a        = x;
    b        = y;
    in_valid = v;
  endtask

  task automatic directed(input string tag,
                          input logic [31:0] x,
                          input logic [31:0] y,
                          input logic [32:0] exp);
    drive(x, y, 1'b1);
    tick(tag);
    for (int i = 1; i < LAT; i++) begin
      drive(32'h0, 32'h0, 1'b0);
      tick({tag, ".fill"});
    end
    chk({tag, ".abs"}, s, exp);
  endtask

  initial begin
    rst = 1'b1;
    drive(32'hFFFF_FFFF, 32'h1, 1'b1);
    tick("rst0");
    chk("rst0.zero", s, 33'h0);
    tick("rst1");
    chk("rst1.zero", {32'b0, out_valid}, 33'h0);
    rst = 1'b0;

    directed("carry", 32'hFFFF_FFFF, 32'h1, 33'h1_0000_0000);
    directed("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE);
    directed("zero", 32'h0, 32'h0, 33'h0);
    directed("grp4", 32'h0000_000F, 32'h1, 33'h10);
    directed("grp28", 32'h0FFF_FFFF, 32'h1, 33'h1000_0000);
    directed("grp31", 32'h7FFF_FFFF, 32'h1, 33'h0_8000_0000);
    directed("alt", 32'hAAAA_AAAA, 32'h5555_5555, 33'h0_FFFF_FFFF);

    for (int i = 0; i < 160; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)));
      tick("rand");
    end

    for (int i = 0; i < 5; i++) begin
      drive($urandom, $urandom, 1'b1);
      tick("pre_flush");
    end
    rst = 1'b1;
    drive($urandom, $urandom, 1'b1);
    tick("flush_rst");
    chk("flush0.v", {32'b0, out_valid}, 33'h0);
    rst = 1'b0;
    drive($urandom, $urandom, 1'b1);
    tick("flush1");
    if (LAT == 2) chk("flush1.v", {32'b0, out_valid}, 33'h0);
    for (int i = 0; i < 40; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)));
      tick("post");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
